// File: rtl/axil_rd_vote_pkg.sv
// Shared types and constants for the replicated-read voting stage.
package axil_rd_vote_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VOTE    = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_rd_vote_if.sv
// Bundle of the per-lane R channels in and the voted R channel out.
interface axil_rd_vote_if #(
    parameter int M_COUNT    = 3,
    parameter int DATA_WIDTH = 32
);
    logic [M_COUNT*DATA_WIDTH-1:0] in_rdata;
    logic [M_COUNT*2-1:0]          in_rresp;
    logic [M_COUNT-1:0]            in_rvalid;
    logic [M_COUNT-1:0]            in_rready;
    logic [DATA_WIDTH-1:0]         out_rdata;
    logic [1:0]                    out_rresp;
    logic                          out_rvalid;
    logic                          out_rready;
    logic [M_COUNT-1:0]            out_mismatch;
    logic                          out_timeout;

    // master: the voting stage itself
    modport master (
        input  in_rdata, in_rresp, in_rvalid, out_rready,
        output in_rready, out_rdata, out_rresp, out_rvalid, out_mismatch, out_timeout
    );

    // slave: the replicated lanes plus the downstream consumer
    modport slave (
        output in_rdata, in_rresp, in_rvalid, out_rready,
        input  in_rready, out_rdata, out_rresp, out_rvalid, out_mismatch, out_timeout
    );
endinterface

// File: rtl/axil_rd_vote_maj.sv
// Bitwise majority over the lanes selected by mask; an exact tie takes the
// bit of the lowest-indexed selected lane, and an empty mask yields zero.
module axil_rd_vote_maj #(
    parameter int M_COUNT = 3,
    parameter int WIDTH   = 32
) (
    input  logic [M_COUNT*WIDTH-1:0] lanes,
    input  logic [M_COUNT-1:0]       mask,
    output logic [WIDTH-1:0]         voted
);
    localparam int CW = $clog2(M_COUNT + 1);
    localparam int IW = $clog2(M_COUNT);

    logic [CW-1:0] n_cap;
    logic [IW-1:0] low_idx;
    logic          any_cap;

    always_comb begin
        n_cap   = '0;
        low_idx = '0;
        any_cap = 1'b0;
        for (int n = M_COUNT - 1; n >= 0; n--) begin
            if (mask[n]) begin
                n_cap   = n_cap + 1'b1;
                low_idx = IW'(n);
                any_cap = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [M_COUNT-1:0] col;
        logic [CW-1:0]      ones;
        logic [CW:0]        twice;

        always_comb begin
            col  = '0;
            ones = '0;
            for (int n = 0; n < M_COUNT; n++) begin
                col[n] = lanes[n*WIDTH + gi];
                if (mask[n] && col[n])
                    ones = ones + 1'b1;
            end
        end

        assign twice     = {ones, 1'b0};
        assign voted[gi] = (twice > {1'b0, n_cap})
                         | ((twice == {1'b0, n_cap}) & any_cap & col[low_idx]);
    end

endmodule

// File: rtl/axil_rd_vote.sv
// Collects one R beat per replicated lane, votes them bitwise and emits one
// beat with per-lane mismatch flags. Optional AXIL_RD_VOTE_STATS_EN adds a mismatch counter.
module axil_rd_vote #(
    parameter int M_COUNT    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_start,
    axil_rd_vote_if.master       bus,
    output logic [CNT_WIDTH-1:0] stat_mismatch_count
);
    import axil_rd_vote_pkg::*;

    state_t                        state_reg, state_next;
    logic [M_COUNT-1:0]            captured_reg, captured_next;
    logic [M_COUNT-1:0]            owed_reg, owed_next;
    logic [M_COUNT-1:0]            rready_reg, rready_next;
    logic [31:0]                   timer_reg, timer_next;
    logic                          timeout_reg, timeout_next;
    logic [M_COUNT-1:0]            hs;
    logic                          expire;
    logic [M_COUNT*DATA_WIDTH-1:0] lane_data_reg;
    logic [M_COUNT*2-1:0]          lane_resp_reg;
    logic [DATA_WIDTH-1:0]         voted_data;
    logic [1:0]                    voted_resp;
    logic [M_COUNT-1:0]            mismatch_vote;
    logic [DATA_WIDTH-1:0]         out_rdata_reg;
    logic [1:0]                    out_rresp_reg;
    logic                          out_rvalid_reg;
    logic [M_COUNT-1:0]            out_mismatch_reg;
    logic                          out_timeout_reg;

    assign hs     = bus.in_rvalid & rready_reg;
    assign expire = (TIMEOUT != 0) && (timer_reg == 32'd1);

    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (s_start) state_next = ST_COLLECT;
            ST_COLLECT: if ((&captured_next) || expire) state_next = ST_VOTE;
            ST_VOTE:    state_next = ST_OUTPUT;
            ST_OUTPUT:  if (bus.out_rready) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Owed lanes are drained in every state; a beat on an owed lane is never captured.
    always_comb begin
        captured_next = captured_reg;
        owed_next     = owed_reg & ~hs;
        timer_next    = timer_reg;
        timeout_next  = timeout_reg;
        case (state_reg)
            ST_IDLE: begin
                if (s_start) begin
                    captured_next = '0;
                    timer_next    = 32'(TIMEOUT);
                    timeout_next  = 1'b0;
                end
            end
            ST_COLLECT: begin
                captured_next = captured_reg | (hs & ~owed_reg);
                timer_next    = timer_reg - 32'd1;
                if (!(&captured_next) && expire) begin
                    timeout_next = 1'b1;
                    owed_next    = owed_next | ~captured_next;
                end
            end
            default: ;
        endcase
        rready_next = (state_next == ST_COLLECT) ? (~captured_next | owed_next) : owed_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            captured_reg     <= '0;
            owed_reg         <= '0;
            rready_reg       <= '0;
            timer_reg        <= '0;
            timeout_reg      <= 1'b0;
            out_rdata_reg    <= '0;
            out_rresp_reg    <= RESP_OKAY;
            out_rvalid_reg   <= 1'b0;
            out_mismatch_reg <= '0;
            out_timeout_reg  <= 1'b0;
        end else begin
            captured_reg <= captured_next;
            owed_reg     <= owed_next;
            rready_reg   <= rready_next;
            timer_reg    <= timer_next;
            timeout_reg  <= timeout_next;
            if (state_reg == ST_VOTE) begin
                out_rdata_reg    <= voted_data;
                out_rresp_reg    <= timeout_reg ? RESP_SLVERR : voted_resp;
                out_mismatch_reg <= mismatch_vote;
                out_timeout_reg  <= timeout_reg;
                out_rvalid_reg   <= 1'b1;
            end else if (state_reg == ST_OUTPUT && bus.out_rready) begin
                out_rvalid_reg   <= 1'b0;
            end
        end
    end

    // Lane buffers are only meaningful under captured_reg, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int n = 0; n < M_COUNT; n++) begin
            if (state_reg == ST_COLLECT && hs[n] && !owed_reg[n]) begin
                lane_data_reg[n*DATA_WIDTH +: DATA_WIDTH] <= bus.in_rdata[n*DATA_WIDTH +: DATA_WIDTH];
                lane_resp_reg[n*2 +: 2]                   <= bus.in_rresp[n*2 +: 2];
            end
        end
    end

    axil_rd_vote_maj #(.M_COUNT(M_COUNT), .WIDTH(DATA_WIDTH)) u_maj_data (
        .lanes (lane_data_reg),
        .mask  (captured_reg),
        .voted (voted_data)
    );

    axil_rd_vote_maj #(.M_COUNT(M_COUNT), .WIDTH(2)) u_maj_resp (
        .lanes (lane_resp_reg),
        .mask  (captured_reg),
        .voted (voted_resp)
    );

    for (genvar gi = 0; gi < M_COUNT; gi++) begin : g_mis
        assign mismatch_vote[gi] = ~captured_reg[gi]
                                 | (lane_data_reg[gi*DATA_WIDTH +: DATA_WIDTH] != voted_data)
                                 | (lane_resp_reg[gi*2 +: 2] != voted_resp);
    end

`ifdef AXIL_RD_VOTE_STATS_EN
    logic [CNT_WIDTH-1:0] stat_reg;

    always_ff @(posedge clk) begin
        if (rst)
            stat_reg <= '0;
        else if (out_rvalid_reg && bus.out_rready && (|out_mismatch_reg) && !(&stat_reg))
            stat_reg <= stat_reg + 1'b1;
    end

    assign stat_mismatch_count = stat_reg;
`else
    assign stat_mismatch_count = '0;
`endif

    assign bus.in_rready    = rready_reg;
    assign bus.out_rdata    = out_rdata_reg;
    assign bus.out_rresp    = out_rresp_reg;
    assign bus.out_rvalid   = out_rvalid_reg;
    assign bus.out_mismatch = out_mismatch_reg;
    assign bus.out_timeout  = out_timeout_reg;

endmodule
